// File: rtl/rate_div_pkg.sv
// -----------------------------------------------------------------------------
// rate_div_pkg
// Shared constants for the rate divider bank.
//   CNT_W_DEF       default divisor/counter width
//   DEFAULT_DIV_DEF default divisor loaded into every channel at reset
//   CH_IDX_W        width of the configuration channel index
// Optional feature macro used by the bank: RATE_DIV_SYNC_EN.
// -----------------------------------------------------------------------------
package rate_div_pkg;

   localparam int unsigned CNT_W_DEF       = 27;
   localparam int unsigned DEFAULT_DIV_DEF = 833332;
   localparam int unsigned CH_IDX_W        = 4;
   localparam int unsigned MAX_CH          = 1 << CH_IDX_W;

   // True when a configuration write addressed to ch_idx targets channel ch.
   function automatic logic cfg_hit(input logic [CH_IDX_W-1:0] ch_idx,
                                    input int unsigned         ch);
      return ch_idx == CH_IDX_W'(ch);
   endfunction

endpackage

// File: rtl/rate_div_bank_if.sv
// -----------------------------------------------------------------------------
// rate_div_bank_if
// Groups the run enables, the divisor write port and the divider outputs.
//   en      [NUM_CH]   per-channel run enable (level)
//   cfg_we             divisor write strobe (one cycle)
//   cfg_ch  [CH_IDX_W] channel index for the write
//   cfg_div [CNT_W]    new divisor value
//   tick    [NUM_CH]   one-cycle pulse per channel period
//   level   [NUM_CH]   square wave, toggles on every tick
// Modports: master drives enables/config, slave (the bank) drives outputs.
// -----------------------------------------------------------------------------
interface rate_div_bank_if
   import rate_div_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = CNT_W_DEF
);

   logic [NUM_CH-1:0]   en;
   logic                cfg_we;
   logic [CH_IDX_W-1:0] cfg_ch;
   logic [CNT_W-1:0]    cfg_div;
   logic [NUM_CH-1:0]   tick;
   logic [NUM_CH-1:0]   level;

   modport master (
      output en,
      output cfg_we,
      output cfg_ch,
      output cfg_div,
      input  tick,
      input  level
   );

   modport slave (
      input  en,
      input  cfg_we,
      input  cfg_ch,
      input  cfg_div,
      output tick,
      output level
   );

endinterface

// File: rtl/rate_div_chan.sv
// -----------------------------------------------------------------------------
// rate_div_chan
// One divider channel: divisor register, down-counter, tick pulse and level.
// The counter runs only while en is high; on reaching zero it reloads the
// divisor, emits a one-cycle tick and toggles level, so the tick period is
// div+1 enabled cycles. A divisor write loads both divisor and counter and
// takes priority over a coinciding terminal count.
// Ports:
//   clk     clock, rising edge
//   reset   asynchronous active-high reset
//   sync    (RATE_DIV_SYNC_EN only) reload counter, clear tick and level
//   en      run enable
//   wr      divisor write strobe, already decoded for this channel
//   wr_div  divisor value to write
//   tick    registered one-cycle pulse at terminal count
//   level   registered square wave
// Optional feature macro: RATE_DIV_SYNC_EN.
// -----------------------------------------------------------------------------
module rate_div_chan
   import rate_div_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk,
   input  logic             reset,
`ifdef RATE_DIV_SYNC_EN
   input  logic             sync,
`endif
   input  logic             en,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   output logic             tick,
   output logic             level
);

   localparam logic [CNT_W-1:0] RstDiv = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             level_q, level_d;

   always_comb begin
      div_d   = div_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      level_d = level_q;

`ifdef RATE_DIV_SYNC_EN
      if (sync) begin
         // Realign: overrides enable and terminal count.
         cnt_d   = div_q;
         level_d = 1'b0;
      end else
`endif
      if (en && !wr) begin
         if (cnt_q == '0) begin
            cnt_d   = div_q;
            tick_d  = 1'b1;
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      // A write always lands, even alongside sync or terminal count.
      if (wr) begin
         div_d = wr_div;
         cnt_d = wr_div;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q   <= RstDiv;
         cnt_q   <= RstDiv;
         tick_q  <= 1'b0;
         level_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         level_q <= level_d;
      end
   end

   assign tick  = tick_q;
   assign level = level_q;

endmodule

// File: rtl/rate_div_bank.sv
// -----------------------------------------------------------------------------
// rate_div_bank
// Bank of NUM_CH independent programmable rate dividers. Write decode for the
// divisor port lives here; each channel is a rate_div_chan instance. Writes
// with cfg_ch >= NUM_CH match no channel and are dropped.
// Parameters:
//   NUM_CH       number of channels (1..16)
//   CNT_W        divisor/counter width
//   DEFAULT_DIV  divisor loaded into every channel at reset
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-high reset
//   sync   (RATE_DIV_SYNC_EN only) reload all counters, clear ticks and levels
//   bus    rate_div_bank_if.slave: en, cfg_we, cfg_ch, cfg_div in; tick, level out
// Optional feature macro: RATE_DIV_SYNC_EN adds the sync input.
// -----------------------------------------------------------------------------
module rate_div_bank
   import rate_div_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic           clk,
   input  logic           reset,
`ifdef RATE_DIV_SYNC_EN
   input  logic           sync,
`endif
   rate_div_bank_if.slave bus
);

   logic [NUM_CH-1:0] wr_vec;
   logic [NUM_CH-1:0] tick_vec;
   logic [NUM_CH-1:0] level_vec;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      assign wr_vec[c] = bus.cfg_we && cfg_hit(bus.cfg_ch, c);

      rate_div_chan #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk    (clk),
         .reset  (reset),
`ifdef RATE_DIV_SYNC_EN
         .sync   (sync),
`endif
         .en     (bus.en[c]),
         .wr     (wr_vec[c]),
         .wr_div (bus.cfg_div),
         .tick   (tick_vec[c]),
         .level  (level_vec[c])
      );
   end

   // Outputs come straight from the channel flops.
   assign bus.tick  = tick_vec;
   assign bus.level = level_vec;

endmodule

// File: tb/tb_rate_div_bank.sv
// -----------------------------------------------------------------------------
// tb_rate_div_bank
// Self-checking bench for rate_div_bank with NUM_CH=4, CNT_W=8, DEFAULT_DIV=3.
// A reference model tracks, per channel, how many enabled cycles remain until
// the next tick; it is compared against tick and level on every cycle.
// Directed scenarios pin literal timings; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_rate_div_bank;
   import rate_div_pkg::*;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DEF    = 3;

   logic clk;
   logic reset;
   logic sync;

   rate_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   rate_div_bank #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEF)
   ) dut (
      .clk   (clk),
      .reset (reset),
`ifdef RATE_DIV_SYNC_EN
      .sync  (sync),
`endif
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   int unsigned        div_m  [NUM_CH];
   int unsigned        left_m [NUM_CH];  // enabled cycles until next tick
   logic [NUM_CH-1:0]  tick_m;
   logic [NUM_CH-1:0]  level_m;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            div_m[c]  = DEF;
            left_m[c] = DEF + 1;
         end
         tick_m  = '0;
         level_m = '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            bit hit;
            hit = bus.cfg_we && (int'(bus.cfg_ch) == c);
            tick_m[c] = 1'b0;
            if (sync === 1'b1) begin
               left_m[c]  = div_m[c] + 1;
               level_m[c] = 1'b0;
            end else if (bus.en[c] && !hit) begin
               left_m[c] = left_m[c] - 1;
               if (left_m[c] == 0) begin
                  tick_m[c]  = 1'b1;
                  level_m[c] = ~level_m[c];
                  left_m[c]  = div_m[c] + 1;
               end
            end
            if (hit) begin
               div_m[c]  = int'(bus.cfg_div);
               left_m[c] = int'(bus.cfg_div) + 1;
            end
         end
      end
   endtask

   // Single compare process: model advances at each edge, DUT checked 1 unit later.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("tick", 32'(bus.tick), 32'(tick_m));
         chk("level", 32'(bus.level), 32'(level_m));
      end
   end

   // Advance one clock; returns 2 units after the edge, clear of sampling.
   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input int unsigned ch, input int unsigned d);
      bus.cfg_we  = 1'b1;
      bus.cfg_ch  = CH_IDX_W'(ch);
      bus.cfg_div = CNT_W'(d);
   endtask

   initial begin
      reset       = 1'b1;
      sync        = 1'b0;
      bus.en      = '0;
      bus.cfg_we  = 1'b0;
      bus.cfg_ch  = '0;
      bus.cfg_div = '0;

      nxt();
      nxt();
      chk("rst_tick", 32'(bus.tick), 32'h0);
      chk("rst_level", 32'(bus.level), 32'h0);

      // Reset release, only channel 0 running with the default divisor of 3.
      reset  = 1'b0;
      bus.en = 4'b0001;
      nxt();
      nxt();
      nxt();
      chk("p029_no_tick_early", 32'(bus.tick), 32'h0);
      nxt();
      chk("p029_first_tick", 32'(bus.tick), 32'h1);
      chk("p029_level_hi", 32'(bus.level), 32'h1);
      chk("model_pin_tick0", 32'(tick_m), 32'h1);
      nxt();
      nxt();
      nxt();
      nxt();
      chk("p029_second_tick", 32'(bus.tick), 32'h1);
      chk("p029_level_lo", 32'(bus.level), 32'h0);

      // Channel 2 divisor 0: tick every cycle from the second cycle on.
      bus.en = 4'b0101;
      wr(2, 0);
      nxt();
      bus.cfg_we = 1'b0;
      chk("p030_tick_c1", 32'(bus.tick[2]), 32'h0);
      nxt();
      chk("p030_tick_c2", 32'(bus.tick[2]), 32'h1);
      chk("p030_level_c2", 32'(bus.level[2]), 32'h1);
      nxt();
      chk("p030_tick_c3", 32'(bus.tick[2]), 32'h1);
      chk("p030_level_c3", 32'(bus.level[2]), 32'h0);
      bus.en[2] = 1'b0;

      // Channel 1 divisor 5, stalled two cycles at count 3.
      bus.en[1] = 1'b1;
      wr(1, 5);
      nxt();
      bus.cfg_we = 1'b0;
      nxt();
      nxt();
      bus.en[1] = 1'b0;
      nxt();
      nxt();
      bus.en[1] = 1'b1;
      nxt();
      chk("p031_no_tick_undelayed", 32'(bus.tick[1]), 32'h0);
      nxt();
      nxt();
      chk("p031_no_tick_p8", 32'(bus.tick[1]), 32'h0);
      nxt();
      chk("p031_delayed_tick", 32'(bus.tick[1]), 32'h1);
      bus.en[1] = 1'b0;

      // Channel 0: write divisor 9 on its terminal-count cycle.
      wr(0, 3);
      nxt();
      bus.cfg_we = 1'b0;
      nxt();
      nxt();
      nxt();
      wr(0, 9);
      nxt();
      bus.cfg_we = 1'b0;
      chk("p032_write_wins", 32'(bus.tick[0]), 32'h0);
      for (int i = 0; i < 9; i++) nxt();
      chk("p032_no_tick_p14", 32'(bus.tick[0]), 32'h0);
      nxt();
      chk("p032_tick_p15", 32'(bus.tick[0]), 32'h1);

      // Out-of-range channel indices must be dropped.
      bus.en = 4'b1111;
      wr(7, 1);
      nxt();
      wr(15, 2);
      nxt();
      wr(4, 0);
      nxt();
      bus.cfg_we = 1'b0;
      for (int i = 0; i < 12; i++) nxt();

      // Reset mid-count clears outputs immediately.
      reset = 1'b1;
      #1;
      chk("p033_async_tick", 32'(bus.tick), 32'h0);
      chk("p033_async_level", 32'(bus.level), 32'h0);
      nxt();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) nxt();
      chk("p024_no_tick_early", 32'(bus.tick), 32'h0);
      nxt();
      chk("p024_first_tick", 32'(bus.tick), 32'hF);

`ifdef RATE_DIV_SYNC_EN
      wr(0, 4);
      nxt();
      wr(1, 4);
      nxt();
      wr(2, 4);
      nxt();
      bus.cfg_we = 1'b0;
      nxt();
      sync = 1'b1;
      nxt();
      sync = 1'b0;
      chk("p034_level_clr", 32'(bus.level), 32'h0);
      chk("p034_tick_clr", 32'(bus.tick), 32'h0);
      for (int i = 0; i < 4; i++) nxt();
      nxt();
      chk("p034_aligned", 32'(bus.tick[2:0]), 32'h7);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bus.en = NUM_CH'($urandom);
         if ($urandom_range(0, 7) == 0) wr($urandom_range(0, 15), $urandom_range(0, 12));
         else bus.cfg_we = 1'b0;
`ifdef RATE_DIV_SYNC_EN
         sync = ($urandom_range(0, 63) == 0);
`endif
         reset = ($urandom_range(0, 499) == 0);
         nxt();
      end
      reset      = 1'b0;
      sync       = 1'b0;
      bus.cfg_we = 1'b0;
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
